// File: rtl/ddr_lane_gearbox_if.sv
// Handshake bundle between the sample source, the gearbox and the DDR serializer.
// Five samples enter per beat and four leave per beat.
interface ddr_lane_gearbox_if #(
  parameter int SW  = 14,
  parameter int BUF = 16
) ();
  logic                            in_valid;
  logic                            in_ready;
  logic [4:0][SW-1:0]              in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [3:0][SW-1:0]              out_data;
  logic [$clog2(BUF+1)-1:0]        level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/ddr_lane_gearbox.sv
// 5:4 sample gearbox feeding the 2-lane DDR serializer through a circular buffer.
// Emits lane0 rise, lane1 rise, lane0 fall, lane1 fall in stream order.
module ddr_lane_gearbox #(
  parameter int SW  = 14,
  parameter int BUF = 16
) (
  input  logic                clk,
  input  logic                reset,
  ddr_lane_gearbox_if.slave   bus
);
  localparam int PW = $clog2(BUF);
  localparam int LW = $clog2(BUF + 1);
  localparam logic [LW-1:0] IN_MAX = LW'(BUF - 5);

  logic [SW-1:0] mem_q [BUF];
  logic [SW-1:0] mem_d [BUF];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          push_s, pop_s;

  // Next-state: pointers, level, storage writes and the handshake flags for the next cycle.
  always_comb begin
    push_s   = bus.in_valid & in_ready_q;
    pop_s    = out_valid_q & bus.out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(5);
      level_d  = level_d + LW'(5);
      for (int k = 0; k < 5; k++) begin
        mem_d[wr_ptr_q + PW'(k)] = bus.in_data[k];
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(4);
      level_d  = level_d - LW'(4);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Flags are precomputed from the next level so they stay pure flops of level.
    in_ready_d  = (level_d <= IN_MAX);
    out_valid_d = (level_d >= LW'(4));
  end

  // Control state; reset discards buffered samples and overrides any push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Sample storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output window is a direct mux from storage, zeroed while fewer than four samples are held.
  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid_q) begin
        bus.out_data[k] = mem_q[rd_ptr_q + PW'(k)];
      end else begin
        bus.out_data[k] = '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.level     = level_q;

endmodule
